// File: rtl/pq_push_ctrl.sv
// pq_push_ctrl: tags priority words with free-list IDs and drives {data,id} cells into the PQ push port.
// Define PQ_PUSH_ID_ROTATE_EN for round-robin ID allocation; lowest-free-index allocation otherwise.
module pq_push_ctrl #(
  parameter int QUEUE_DEPTH = 3,
  parameter int DATA_WIDTH = 16,
  localparam int ID_WIDTH = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [DATA_WIDTH-1:0]        req_data_i,
  output logic [ID_WIDTH-1:0]          req_id_o,
  output logic                         push_valid_o,
  input  logic                         push_ready_i,
  output logic [DATA_WIDTH+ID_WIDTH-1:0] push_cell_o,
  input  logic                         rel_valid_i,
  input  logic [ID_WIDTH-1:0]          rel_id_i,
  output logic [ID_WIDTH:0]            used_cnt_o,
  output logic                         rel_err_o
);
  localparam int NUM_IDS = 2 ** ID_WIDTH;
  localparam logic [ID_WIDTH:0] DEPTH = (ID_WIDTH + 1)'(QUEUE_DEPTH);
  localparam logic [ID_WIDTH:0] ONE = (ID_WIDTH + 1)'(1);
  logic [NUM_IDS-1:0] bitmap_q, bitmap_d;
  logic [ID_WIDTH:0] cnt_q, cnt_d;
  logic push_valid_q, push_valid_d;
  logic [DATA_WIDTH+ID_WIDTH-1:0] push_cell_q, push_cell_d;
  logic rel_err_q, rel_err_d;
  logic [ID_WIDTH-1:0] alloc_id;
  logic accept, rel_hit;
`ifdef PQ_PUSH_ID_ROTATE_EN
  logic [ID_WIDTH-1:0] last_q, last_d;
  // descending scan so the smallest offset from last_q+1 wins
  always_comb begin
    alloc_id = '0;
    for (int k = NUM_IDS - 1; k >= 0; k--)
      if (!bitmap_q[last_q + ID_WIDTH'(k + 1)]) alloc_id = last_q + ID_WIDTH'(k + 1);
  end
  assign last_d = accept ? alloc_id : last_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) last_q <= '1;
    else last_q <= last_d;
`else
  always_comb begin
    alloc_id = '0;
    for (int k = NUM_IDS - 1; k >= 0; k--)
      if (!bitmap_q[k]) alloc_id = ID_WIDTH'(k);
  end
`endif
  assign req_ready_o = (cnt_q < DEPTH) && (!push_valid_q || push_ready_i);
  assign req_id_o = alloc_id;
  assign accept = req_valid_i && req_ready_o;
  assign rel_hit = rel_valid_i && bitmap_q[rel_id_i];
  // alloc_id comes from the pre-release bitmap, so a just-released ID is never reissued the same cycle
  always_comb begin
    bitmap_d = bitmap_q;
    if (rel_hit) bitmap_d[rel_id_i] = 1'b0;
    if (accept) bitmap_d[alloc_id] = 1'b1;
    cnt_d = (accept && !rel_hit) ? cnt_q + ONE : (!accept && rel_hit) ? cnt_q - ONE : cnt_q;
    push_valid_d = accept || (push_valid_q && !push_ready_i);
    push_cell_d = accept ? {req_data_i, alloc_id} : push_cell_q;
    rel_err_d = rel_valid_i && !bitmap_q[rel_id_i];
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bitmap_q <= '0;
      cnt_q <= '0;
      push_valid_q <= 1'b0;
      push_cell_q <= '0;
      rel_err_q <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      cnt_q <= cnt_d;
      push_valid_q <= push_valid_d;
      push_cell_q <= push_cell_d;
      rel_err_q <= rel_err_d;
    end
  assign push_valid_o = push_valid_q;
  assign push_cell_o = push_cell_q;
  assign used_cnt_o = cnt_q;
  assign rel_err_o = rel_err_q;
endmodule

// File: tb/tb_pq_push_ctrl.sv
// tb_pq_push_ctrl: directed scenarios plus randomized traffic against a free-list reference model.
module tb_pq_push_ctrl;
  localparam int QD = 3;
  localparam int NID = 8;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [15:0] req_data_i = '0;
  logic [2:0] req_id_o;
  logic push_valid_o;
  logic push_ready_i = 1'b0;
  logic [18:0] push_cell_o;
  logic rel_valid_i = 1'b0;
  logic [2:0] rel_id_i = '0;
  logic [3:0] used_cnt_o;
  logic rel_err_o;
  int vectors = 0;
  int errors = 0;
  bit alloc[NID];
  int m_cnt, m_last;
  bit m_pv, m_err;
  logic [18:0] m_cell;
`ifdef PQ_PUSH_ID_ROTATE_EN
  localparam int ROT = 1;
`else
  localparam int ROT = 0;
`endif

  pq_push_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i), .req_id_o(req_id_o),
    .push_valid_o(push_valid_o), .push_ready_i(push_ready_i), .push_cell_o(push_cell_o),
    .rel_valid_i(rel_valid_i), .rel_id_i(rel_id_i), .used_cnt_o(used_cnt_o), .rel_err_o(rel_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_clear();
    foreach (alloc[i]) alloc[i] = 1'b0;
    m_cnt = 0;
    m_last = NID - 1;
    m_pv = 1'b0;
    m_err = 1'b0;
    m_cell = '0;
  endfunction

  function automatic bit m_ready(bit pr);
    return (m_cnt < QD) && (!m_pv || pr);
  endfunction

  function automatic int m_free_id();
    for (int k = 1; k <= NID; k++) begin
      int i;
      i = ROT ? (m_last + k) % NID : k - 1;
      if (!alloc[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    bit acc, rel_ok;
    int id;
    acc = req_valid_i && m_ready(push_ready_i);
    id = m_free_id();
    rel_ok = rel_valid_i && alloc[rel_id_i];
    m_err = rel_valid_i && !alloc[rel_id_i];
    @(posedge clk_i);
    #1;
    if (rel_ok) begin alloc[rel_id_i] = 1'b0; m_cnt--; end
    if (acc) begin
      alloc[id] = 1'b1;
      m_cnt++;
      m_last = id;
      m_pv = 1'b1;
      m_cell = {req_data_i, 3'(id)};
    end else if (push_ready_i) m_pv = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    rel_valid_i = 1'b0;
    push_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    model_clear();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({push_valid_o, push_cell_o, used_cnt_o, rel_err_o} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: got pv=%0b cell=%0h cnt=%0d err=%0b, expected all zero", push_valid_o, push_cell_o, used_cnt_o, rel_err_o);
    end
    do_reset();
    vectors++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", req_ready_o); end
  endtask

  task automatic test_fill();
    logic [15:0] d;
    push_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = 16'((k + 1) * 16);
      req_valid_i = 1'b1;
      req_data_i = d;
      #1;
      vectors++;
      if ({req_ready_o, req_id_o} !== {1'b1, 3'(k)}) begin
        errors++;
        $display("FAIL fill_accept%0d: got ready=%0b id=%0d expected ready=1 id=%0d", k, req_ready_o, req_id_o, k);
      end
      tick();
      vectors++;
      if ({push_valid_o, push_cell_o} !== {1'b1, d, 3'(k)}) begin
        errors++;
        $display("FAIL fill_cell%0d: got pv=%0b cell=%0h expected pv=1 cell=%0h", k, push_valid_o, push_cell_o, {d, 3'(k)});
      end
    end
    req_data_i = 16'h0040;
    #1;
    vectors++;
    if (req_ready_o !== 1'b0 || used_cnt_o !== 4'd3) begin
      errors++;
      $display("FAIL fill_full: got ready=%0b cnt=%0d expected ready=0 cnt=3", req_ready_o, used_cnt_o);
    end
    req_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_release_full();
    logic [2:0] exp_id;
    exp_id = ROT ? 3'd3 : 3'd1;
    rel_valid_i = 1'b1;
    rel_id_i = 3'd1;
    tick();
    rel_valid_i = 1'b0;
    #1;
    vectors++;
    if (req_ready_o !== 1'b1 || used_cnt_o !== 4'd2) begin
      errors++;
      $display("FAIL release_credit: got ready=%0b cnt=%0d expected ready=1 cnt=2", req_ready_o, used_cnt_o);
    end
    req_valid_i = 1'b1;
    req_data_i = 16'h0050;
    #1;
    vectors++;
    if (req_id_o !== exp_id) begin errors++; $display("FAIL release_reuse_id: got %0d expected %0d", req_id_o, exp_id); end
    tick();
    req_valid_i = 1'b0;
    vectors++;
    if (used_cnt_o !== 4'd3 || push_cell_o !== {16'h0050, exp_id}) begin
      errors++;
      $display("FAIL release_refill: got cnt=%0d cell=%0h expected cnt=3 cell=%0h", used_cnt_o, push_cell_o, {16'h0050, exp_id});
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_valid_i = 1'b1;
    req_data_i = 16'hBEEF;
    tick();
    req_data_i = 16'h1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %0b expected 0", k, req_ready_o); end
      tick();
      vectors++;
      if ({push_valid_o, push_cell_o} !== {1'b1, 16'hBEEF, 3'd0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got pv=%0b cell=%0h expected pv=1 cell=%0h", k, push_valid_o, push_cell_o, {16'hBEEF, 3'd0});
      end
    end
    req_valid_i = 1'b0;
    push_ready_i = 1'b1;
    #1;
    vectors++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b expected 1", req_ready_o); end
    tick();
    vectors++;
    if (push_valid_o !== 1'b0 || used_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL stall_drain: got pv=%0b cnt=%0d expected pv=0 cnt=1", push_valid_o, used_cnt_o);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    push_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_data_i = 16'h0A0A;
    tick();
    tick();
    rel_valid_i = 1'b1;
    rel_id_i = 3'd0;
    req_data_i = 16'h0C0C;
    #1;
    vectors++;
    if (req_id_o !== 3'd2) begin errors++; $display("FAIL same_cycle_id: got %0d expected 2", req_id_o); end
    tick();
    rel_valid_i = 1'b0;
    req_valid_i = 1'b0;
    vectors++;
    if (used_cnt_o !== 4'd2 || push_cell_o !== {16'h0C0C, 3'd2}) begin
      errors++;
      $display("FAIL same_cycle_cnt: got cnt=%0d cell=%0h expected cnt=2 cell=%0h", used_cnt_o, push_cell_o, {16'h0C0C, 3'd2});
    end
  endtask

  task automatic test_rel_err();
    do_reset();
    push_ready_i = 1'b1;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    rel_valid_i = 1'b1;
    rel_id_i = 3'd5;
    tick();
    rel_valid_i = 1'b0;
    vectors++;
    if (rel_err_o !== 1'b1 || used_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL rel_err_pulse: got err=%0b cnt=%0d expected err=1 cnt=1", rel_err_o, used_cnt_o);
    end
    tick();
    vectors++;
    if (rel_err_o !== 1'b0) begin errors++; $display("FAIL rel_err_clear: got %0b expected 0", rel_err_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    vectors++;
    if (push_valid_o !== 1'b1) begin errors++; $display("FAIL reset_mid_setup: got pv=%0b expected 1", push_valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (push_valid_o !== 1'b0 || used_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got pv=%0b cnt=%0d expected pv=0 cnt=0", push_valid_o, used_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req_valid_i = 1'($urandom_range(0, 1));
      push_ready_i = $urandom_range(0, 3) != 0;
      rel_valid_i = $urandom_range(0, 2) == 0;
      rel_id_i = 3'($urandom_range(0, NID - 1));
      req_data_i = 16'($urandom);
      #1;
      exp_rdy = m_ready(push_ready_i);
      vectors++;
      if (req_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready c=%0d: got %0b expected %0b", c, req_ready_o, exp_rdy);
      end
      if (req_valid_i && exp_rdy) begin
        vectors++;
        if (req_id_o !== 3'(m_free_id())) begin
          errors++;
          $display("FAIL rand_id c=%0d: got %0d expected %0d", c, req_id_o, m_free_id());
        end
      end
      tick();
      vectors++;
      if ({push_valid_o, push_cell_o, used_cnt_o, rel_err_o} !== {m_pv, m_cell, 4'(m_cnt), m_err}) begin
        errors++;
        $display("FAIL rand_state c=%0d: got pv=%0b cell=%0h cnt=%0d err=%0b expected pv=%0b cell=%0h cnt=%0d err=%0b",
                 c, push_valid_o, push_cell_o, used_cnt_o, rel_err_o, m_pv, m_cell, m_cnt, m_err);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_release_full();
    test_stall();
    test_same_cycle();
    test_rel_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
